// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG sample packer: FSM state encoding,
// default geometry and the level-counter width helper.
package trng_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_FAIL    = 2'd2
   } state_e;

   localparam int DEF_WORD_WIDTH = 32;
   localparam int DEF_DEPTH      = 8;
   localparam int DEF_RCT_CUTOFF = 32;

   // One extra bit so the counter can hold DEPTH itself.
   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with an explicit level counter.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo
   import trng_pkg::*;
#(
   parameter int WIDTH = DEF_WORD_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                        clk,
   input  logic                        srst,
   input  logic                        push_i,
   input  logic [WIDTH-1:0]            din_i,
   input  logic                        pop_i,
   output logic [WIDTH-1:0]            dout_o,
   output logic                        empty_o,
   output logic                        full_o,
   output logic [level_w(DEPTH)-1:0]   level_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = level_w(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             pop_ok, push_ok;

   always_comb begin
      pop_ok   = pop_i && (level_q != '0);
      push_ok  = push_i && ((level_q != LW'(DEPTH)) || pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      level_d = level_q + LW'(push_ok) - LW'(pop_ok);
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LW'(DEPTH));
   assign level_o = level_q;
   assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/trng_sample_packer.sv
// Raw TRNG bit collector: repetition-count health test, MSB-first packing
// into words, and a FWFT FIFO drained by the bus side.
module trng_sample_packer
   import trng_pkg::*;
#(
   parameter int WORD_WIDTH = DEF_WORD_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int RCT_CUTOFF = DEF_RCT_CUTOFF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en_i,
   input  logic                        bit_valid_i,
   input  logic                        bit_i,
   input  logic                        clear_i,
   input  logic                        rd_en_i,
   output logic [WORD_WIDTH-1:0]       data_o,
   output logic                        empty_o,
   output logic                        full_o,
   output logic [level_w(DEPTH)-1:0]   level_o,
   output logic                        rct_fail_o,
   output logic                        overflow_o
);

   localparam int CNT_W = $clog2(WORD_WIDTH);

   // bit_valid_i is a strobe with no back-pressure: a bit is consumed or
   // dropped in its cycle. rd_en_i pops only when empty_o is low.
   state_e                 state_q, state_d;
   logic [WORD_WIDTH-1:0]  shreg_q, shreg_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]             run_q, run_d;
   logic                   last_q, last_d;
   logic                   rct_fail_q, rct_fail_d;
   logic                   overflow_q, overflow_d;

   logic                   srst;
   logic                   accept;
   logic [7:0]             run_next;
   logic [WORD_WIDTH-1:0]  push_word;
   logic                   push_en;
   logic                   fifo_full;

   assign srst = rst | clear_i;

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      run_d      = run_q;
      last_d     = last_q;
      rct_fail_d = rct_fail_q;
      push_en    = 1'b0;
      push_word  = {shreg_q[WORD_WIDTH-2:0], bit_i};
      accept     = bit_valid_i && en_i && (state_q != ST_FAIL);
      // run_q == 0 marks "no bit seen since reset/clear".
      run_next   = ((run_q != 8'd0) && (bit_i == last_q)) ? run_q + 8'd1 : 8'd1;

      case (state_q)
         ST_IDLE:    if (en_i)  state_d = ST_COLLECT;
         ST_COLLECT: if (!en_i) state_d = ST_IDLE;
         ST_FAIL:    state_d = ST_FAIL;
         default:    state_d = ST_IDLE;
      endcase

      if (accept) begin
         if (run_next == 8'(RCT_CUTOFF)) begin
            rct_fail_d = 1'b1;
            bit_cnt_d  = '0;
            state_d    = ST_FAIL;
         end else begin
            shreg_d = push_word;
            run_d   = run_next;
            last_d  = bit_i;
            if (bit_cnt_q == CNT_W'(WORD_WIDTH - 1)) begin
               push_en   = 1'b1;
               bit_cnt_d = '0;
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
      end

      overflow_d = overflow_q | (push_en && fifo_full && !rd_en_i);
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         run_q      <= '0;
         last_q     <= 1'b0;
         rct_fail_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         run_q      <= run_d;
         last_q     <= last_d;
         rct_fail_q <= rct_fail_d;
         overflow_q <= overflow_d;
      end
   end

   sync_fifo #(
      .WIDTH (WORD_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .srst    (srst),
      .push_i  (push_en),
      .din_i   (push_word),
      .pop_i   (rd_en_i),
      .dout_o  (data_o),
      .empty_o (empty_o),
      .full_o  (fifo_full),
      .level_o (level_o)
   );

   assign full_o     = fifo_full;
   assign rct_fail_o = rct_fail_q;
   assign overflow_o = overflow_q;

endmodule

// File: tb/tb_trng_sample_packer.sv
// Bench for trng_sample_packer: bit-level reference model feeding an
// expected-word queue, a table of overflow vectors and hand-written corners.
module tb_trng_sample_packer;

   localparam int W       = 32;
   localparam int DEPTH   = 8;
   localparam int RCT_CUT = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en_i = 1'b0;
   logic          bit_valid_i = 1'b0;
   logic          bit_i = 1'b0;
   logic          clear_i = 1'b0;
   logic          rd_en_i = 1'b0;
   logic [W-1:0]  data_o;
   logic          empty_o;
   logic          full_o;
   logic [3:0]    level_o;
   logic          rct_fail_o;
   logic          overflow_o;

   trng_sample_packer #(
      .WORD_WIDTH (W),
      .DEPTH      (DEPTH),
      .RCT_CUTOFF (RCT_CUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en_i        (en_i),
      .bit_valid_i (bit_valid_i),
      .bit_i       (bit_i),
      .clear_i     (clear_i),
      .rd_en_i     (rd_en_i),
      .data_o      (data_o),
      .empty_o     (empty_o),
      .full_o      (full_o),
      .level_o     (level_o),
      .rct_fail_o  (rct_fail_o),
      .overflow_o  (overflow_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard / reference model ----------------
   int           n_vec = 0;
   int           n_err = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] m_word;
   int           m_cnt;
   int           m_run;
   logic         m_last;
   logic         m_fail;
   logic         m_ovf;
   logic         en;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      m_word = '0;
      m_cnt  = 0;
      m_run  = 0;
      m_last = 1'b0;
      m_fail = 1'b0;
      m_ovf  = 1'b0;
   endfunction

   // Random word whose runs stay far below the cutoff, even across words.
   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] w;
      w = $urandom();
      w = (w & ~32'h0100_0100) | 32'h0001_0001;
      return w;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic cycle(input logic v, input logic b, input logic rd);
      logic         complete;
      logic [W-1:0] w;
      int           nr;
      complete = 1'b0;
      w        = '0;
      if (v && en && !m_fail) begin
         nr = (m_run != 0 && b == m_last) ? m_run + 1 : 1;
         if (nr == RCT_CUT) begin
            m_fail = 1'b1;
            m_cnt  = 0;
         end else begin
            m_word = {m_word[W-2:0], b};
            m_run  = nr;
            m_last = b;
            m_cnt++;
            if (m_cnt == W) begin
               complete = 1'b1;
               w        = m_word;
               m_cnt    = 0;
            end
         end
      end
      if (rd && exp_q.size() > 0) chk("pop_data", data_o, exp_q.pop_front());
      if (complete) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(w);
         else m_ovf = 1'b1;
      end
      en_i        = en;
      bit_valid_i = v;
      bit_i       = b;
      rd_en_i     = rd;
      @(posedge clk);
      @(negedge clk);
      bit_valid_i = 1'b0;
      rd_en_i     = 1'b0;
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic rd_last);
      for (int i = W - 1; i >= 0; i--) cycle(1'b1, w[i], (i == 0) ? rd_last : 1'b0);
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear_i = 1'b0;
      model_reset();
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) cycle(1'b0, 1'b0, 1'b1);
      chk("drain_done", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_level"}, 32'(level_o), 32'(exp_q.size()));
      chk({tag, "_empty"}, 32'(empty_o), 32'(exp_q.size() == 0));
      chk({tag, "_full"}, 32'(full_o), 32'(exp_q.size() == DEPTH));
      chk({tag, "_data"}, data_o, (exp_q.size() > 0) ? exp_q[0] : '0);
      chk({tag, "_rct"}, 32'(rct_fail_o), 32'(m_fail));
      chk({tag, "_ovf"}, 32'(overflow_o), 32'(m_ovf));
   endtask

   // ---------------- test ----------------
   typedef struct {
      logic [W-1:0] word;
      int           exp_level;
      logic         exp_full;
      logic         exp_ovf;
   } vec_t;

   vec_t tab[9];

   initial begin
      logic [W-1:0] w;

      // Word k is byte (k+1) repeated; an all-zero word would trip the RCT.
      for (int k = 0; k < 9; k++) begin
         tab[k].word      = 32'(k + 1) * 32'h0101_0101;
         tab[k].exp_level = (k + 1 > DEPTH) ? DEPTH : k + 1;
         tab[k].exp_full  = (k >= DEPTH - 1);
         tab[k].exp_ovf   = (k == 8);
      end

      model_reset();
      en = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_all("reset");
      chk("reset_data_zero", data_o, 32'h0);

      cycle(1'b0, 1'b0, 1'b1);
      check_all("pop_empty");

      // Alternating word
      en = 1'b1;
      send_word(32'hAAAA_AAAA, 1'b0);
      chk("alt_data", data_o, 32'hAAAA_AAAA);
      chk("alt_level", 32'(level_o), 32'd1);
      cycle(1'b0, 1'b0, 1'b1);
      chk("alt_empty", 32'(empty_o), 32'd1);
      check_all("alt_popped");

      // Overflow table
      do_clear();
      for (int i = 0; i < 9; i++) begin
         send_word(tab[i].word, 1'b0);
         chk("tab_level", 32'(level_o), 32'(tab[i].exp_level));
         chk("tab_full", 32'(full_o), 32'(tab[i].exp_full));
         chk("tab_ovf", 32'(overflow_o), 32'(tab[i].exp_ovf));
         check_all("tab");
      end
      chk("ovf_head", data_o, 32'h0101_0101);
      drain();
      check_all("ovf_drained");

      // RCT failure
      do_clear();
      for (int i = 0; i < RCT_CUT - 1; i++) cycle(1'b1, 1'b1, 1'b0);
      chk("rct_31_nofail", 32'(rct_fail_o), 32'd0);
      check_all("rct_31");
      cycle(1'b1, 1'b1, 1'b0);
      chk("rct_32_fail", 32'(rct_fail_o), 32'd1);
      chk("rct_32_level", 32'(level_o), 32'd0);
      check_all("rct_32");
      for (int i = 0; i < 40; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      check_all("rct_ignored");
      do_clear();
      check_all("rct_clear");
      w = rand_word();
      send_word(w, 1'b0);
      chk("rct_resume", data_o, w);
      check_all("rct_resume");

      // Full FIFO: 32nd bit and pop in the same cycle
      do_clear();
      for (int i = 0; i < DEPTH; i++) send_word(rand_word(), 1'b0);
      check_all("full_pre");
      w = rand_word();
      send_word(w, 1'b1);
      chk("fullpp_level", 32'(level_o), 32'd8);
      chk("fullpp_ovf", 32'(overflow_o), 32'd0);
      chk("fullpp_tail", exp_q[DEPTH-1], w);
      check_all("fullpp");
      drain();
      check_all("fullpp_drained");

      // Enable gating
      do_clear();
      w = rand_word();
      for (int i = W - 1; i >= W - 10; i--) cycle(1'b1, w[i], 1'b0);
      en = 1'b0;
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      check_all("gate_off");
      en = 1'b1;
      for (int i = W - 11; i >= 0; i--) cycle(1'b1, w[i], 1'b0);
      chk("gate_level", 32'(level_o), 32'd1);
      chk("gate_data", data_o, w);
      check_all("gate_done");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
